// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// The IF stage looks up the fetch PC combinationally. The EX stage trains the table and raises a redirect on a mispredict.
module branch_predictor #(
    parameter int ADDR_W   = 32,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int STAT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [STAT_W-1:0]   STAT_MAX = '1;

    logic                valid_reg  [ENTRIES];
    logic [TAG_W-1:0]    tag_reg    [ENTRIES];
    logic [ADDR_W-1:0]   target_reg [ENTRIES];
    logic [CTR_BITS-1:0] ctr_reg    [ENTRIES];

    logic [STAT_W-1:0] stat_branches_reg, stat_branches_next;
    logic [STAT_W-1:0] stat_mispredicts_reg, stat_mispredicts_next;

    // Fetch-side lookup: reads the table as it stands before this cycle's update.
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic [ADDR_W-1:0] lk_seq_pc;

    assign lk_idx      = lookup_pc[IDX_W+1:2];
    assign lk_tag      = lookup_pc[ADDR_W-1:IDX_W+2];
    assign lk_seq_pc   = lookup_pc + ADDR_W'(4);
    assign lk_hit      = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_reg[lk_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? target_reg[lk_idx] : lk_seq_pc;

    // EX-side resolution: compare the path actually taken with the one fetched.
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [ADDR_W-1:0] up_seq_pc;
    logic [ADDR_W-1:0] actual_pc;
    logic [ADDR_W-1:0] predicted_pc;

    assign up_idx       = upd_pc[IDX_W+1:2];
    assign up_tag       = upd_pc[ADDR_W-1:IDX_W+2];
    assign up_seq_pc    = upd_pc + ADDR_W'(4);
    assign up_hit       = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);
    assign actual_pc    = (upd_is_branch && upd_taken) ? upd_target : up_seq_pc;
    assign predicted_pc = upd_pred_taken ? upd_pred_target : up_seq_pc;
    assign redirect     = upd_valid && (actual_pc != predicted_pc);
    assign redirect_pc  = actual_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i] <= 1'b0;
                ctr_reg[i]   <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (upd_is_branch) begin
                if (up_hit) begin
                    if (upd_taken) begin
                        if (ctr_reg[up_idx] != CTR_MAX)
                            ctr_reg[up_idx] <= ctr_reg[up_idx] + 1'b1;
                        target_reg[up_idx] <= upd_target;
                    end else if (ctr_reg[up_idx] != '0) begin
                        ctr_reg[up_idx] <= ctr_reg[up_idx] - 1'b1;
                    end
                end else if (upd_taken) begin
                    valid_reg[up_idx]  <= 1'b1;
                    tag_reg[up_idx]    <= up_tag;
                    target_reg[up_idx] <= upd_target;
                    ctr_reg[up_idx]    <= CTR_WT;
                end
            end else if (up_hit) begin
                // A non-branch whose PC matches an entry is an alias, so the entry is dropped.
                valid_reg[up_idx] <= 1'b0;
            end
        end
    end

    always_comb begin
        stat_branches_next    = stat_branches_reg;
        stat_mispredicts_next = stat_mispredicts_reg;
        if (stat_clr) begin
            stat_branches_next    = '0;
            stat_mispredicts_next = '0;
        end else begin
            if (upd_valid && upd_is_branch && stat_branches_reg != STAT_MAX)
                stat_branches_next = stat_branches_reg + 1'b1;
            if (redirect && stat_mispredicts_reg != STAT_MAX)
                stat_mispredicts_next = stat_mispredicts_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else begin
            stat_branches_reg    <= stat_branches_next;
            stat_mispredicts_reg <= stat_mispredicts_next;
        end
    end

    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
endmodule
